dmem_arbiter: RTL and testbench

Sequences and shares the single-port data memory between two requesters: the pipeline M stage (core port) and a DMA/loader port.
- Round-robin arbitration, one outstanding access at a time.
- Drives the memory's enable, write-enable, address and write-data.
- Returns read data with a done pulse.
- Generates the M-stage stall while a core access is pending.
- Sub-word store/load shaping stays outside this block; it moves whole 32-bit words.

---
 rtl/dmem_arbiter_if.sv | 22 ++
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus for one data-memory port (core M stage or DMA/loader).
interface dmem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  req;
  logic                  we;
  logic [31:0]           addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  done;
  logic [DATA_WIDTH-1:0] rdata;

  // Requester drives the access, arbiter answers with done/rdata
  modport master (
    output req, we, addr, wdata,
    input  done, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output done, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin sequencer sharing a single-port data memory between the core
// M stage and a DMA port; one outstanding whole-word access at a time.
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_arbiter_if.slave         core,
  dmem_arbiter_if.slave         dma,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall_m,
  output logic                  busy
);

  localparam int unsigned CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_CORE = 1'b0,
    GNT_DMA  = 1'b1
  } grant_t;

  state_t                r_state;
  grant_t                r_grant;
  grant_t                r_last_grant;
  logic                  r_we;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  w_pick_core;
  grant_t                w_grant;
  logic                  w_unused;

  // Core wins when alone or when DMA was served last
  assign w_pick_core = core.req && (!dma.req || (r_last_grant == GNT_DMA));
  assign w_grant     = w_pick_core ? GNT_CORE : GNT_DMA;

  // Byte-offset and wrap-around address bits are intentionally dropped
  assign w_unused = ^{core.addr[1:0], core.addr[31:ADDR_WIDTH+2],
                      dma.addr[1:0],  dma.addr[31:ADDR_WIDTH+2]};

  // Status: stall the M stage while a core access is outstanding
  assign stall_m = !rst && core.req && !core.done;
  assign busy    = (r_state != IDLE);

  // Access sequencer: IDLE -> ISSUE -> WAIT -> RESP, all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= GNT_CORE;
      r_last_grant <= GNT_DMA;
      r_we         <= 1'b0;
      r_cnt        <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      core.done    <= 1'b0;
      core.rdata   <= '0;
      dma.done     <= 1'b0;
      dma.rdata    <= '0;
    end else begin
      core.done <= 1'b0;
      dma.done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (core.req || dma.req) begin
            r_grant      <= w_grant;
            r_last_grant <= w_grant;
            mem_en       <= 1'b1;
            r_state      <= ISSUE;
            if (w_pick_core) begin
              r_we      <= core.we;
              mem_we    <= core.we;
              mem_addr  <= core.addr[ADDR_WIDTH+1:2];
              mem_wdata <= core.wdata;
            end else begin
              r_we      <= dma.we;
              mem_we    <= dma.we;
              mem_addr  <= dma.addr[ADDR_WIDTH+1:2];
              mem_wdata <= dma.wdata;
            end
          end
        end
        ISSUE: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          r_cnt   <= CNT_WIDTH'(MEM_LAT - 1);
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_cnt == '0) begin
            if (r_grant == GNT_CORE) begin
              core.done <= 1'b1;
              if (!r_we) core.rdata <= mem_rdata;
            end else begin
              dma.done <= 1'b1;
              if (!r_we) dma.rdata <= mem_rdata;
            end
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - CNT_WIDTH'(1);
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: one arbiter with MEM_LAT=1 and one with MEM_LAT=3, each
// backed by a small behavioural memory.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_WIDTH(32)) c1 ();
  dmem_arbiter_if #(.DATA_WIDTH(32)) d1 ();
  dmem_arbiter_if #(.DATA_WIDTH(32)) c3 ();
  dmem_arbiter_if #(.DATA_WIDTH(32)) d3 ();

  logic        mem_en1, mem_we1, stall1, busy1;
  logic [4:0]  mem_addr1;
  logic [31:0] mem_wdata1, mem_rdata1;
  logic        mem_en3, mem_we3, stall3, busy3;
  logic [4:0]  mem_addr3;
  logic [31:0] mem_wdata3, mem_rdata3;

  dmem_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .core(c1), .dma(d1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
    .stall_m(stall1), .busy(busy1)
  );

  dmem_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .core(c3), .dma(d3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
    .stall_m(stall3), .busy(busy3)
  );

  // Memories: word i holds 0xC0DE000i except word 2 = 0xDEADBEEF; read data
  // is non-zero only in the single cycle MEM_LAT after the mem_en cycle.
  logic [31:0] mem1 [32];
  logic [31:0] mem3 [32];
  logic [31:0] q1, q3a, q3b, q3c;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem1[i] <= 32'hC0DE_0000 | 32'(i);
      mem1[2] <= 32'hDEAD_BEEF;
      q1 <= '0;
    end else begin
      if (mem_en1 && mem_we1) mem1[mem_addr1] <= mem_wdata1;
      q1 <= (mem_en1 && !mem_we1) ? mem1[mem_addr1] : 32'h0;
    end
  end
  assign mem_rdata1 = q1;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem3[i] <= 32'hC0DE_0000 | 32'(i);
      mem3[2] <= 32'hDEAD_BEEF;
      q3a <= '0; q3b <= '0; q3c <= '0;
    end else begin
      if (mem_en3 && mem_we3) mem3[mem_addr3] <= mem_wdata3;
      q3a <= (mem_en3 && !mem_we3) ? mem3[mem_addr3] : 32'h0;
      q3b <= q3a;
      q3c <= q3b;
    end
  end
  assign mem_rdata3 = q3c;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    c1.req = 0; c1.we = 0; c1.addr = '0; c1.wdata = '0;
    d1.req = 0; d1.we = 0; d1.addr = '0; d1.wdata = '0;
    c3.req = 0; c3.we = 0; c3.addr = '0; c3.wdata = '0;
    d3.req = 0; d3.we = 0; d3.addr = '0; d3.wdata = '0;

    // Reset state
    step(); step();
    c1.req = 1'b1; #1;
    chk("rst_stall", 32'(stall1), 32'd0);
    c1.req = 1'b0;
    chk("rst_mem_en", 32'(mem_en1), 32'd0);
    chk("rst_c_done", 32'(c1.done), 32'd0);
    chk("rst_c_rdata", c1.rdata, 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Both held after reset: core, DMA, core, DMA
    c1.req = 1; c1.we = 0; c1.addr = 32'h18;
    d1.req = 1; d1.we = 0; d1.addr = 32'h0C;
    #1;
    chk("rr_stall_t", 32'(stall1), 32'd1);
    step();
    chk("rr1_en", 32'(mem_en1), 32'd1);
    chk("rr1_addr", 32'(mem_addr1), 32'd6);
    step(); step();
    chk("rr1_c_done", 32'(c1.done), 32'd1);
    chk("rr1_d_done", 32'(d1.done), 32'd0);
    chk("rr1_c_rdata", c1.rdata, 32'hC0DE_0006);
    chk("rr1_stall", 32'(stall1), 32'd0);
    step();
    chk("rr2_stall_idle", 32'(stall1), 32'd1);
    step();
    chk("rr2_addr", 32'(mem_addr1), 32'd3);
    step(); step();
    chk("rr2_d_done", 32'(d1.done), 32'd1);
    chk("rr2_d_rdata", d1.rdata, 32'hC0DE_0003);
    chk("rr2_c_done", 32'(c1.done), 32'd0);
    chk("rr2_stall", 32'(stall1), 32'd1);
    step(); step();
    chk("rr3_addr", 32'(mem_addr1), 32'd6);
    step(); step();
    chk("rr3_c_done", 32'(c1.done), 32'd1);
    step(); step();
    chk("rr4_addr", 32'(mem_addr1), 32'd3);
    step(); step();
    chk("rr4_d_done", 32'(d1.done), 32'd1);
    c1.req = 0; d1.req = 0;
    step();
    chk("rr_busy_end", 32'(busy1), 32'd0);

    // Core read of 0x8
    c1.req = 1; c1.we = 0; c1.addr = 32'h8;
    #1;
    chk("rd_stall_t", 32'(stall1), 32'd1);
    step();
    chk("rd_en", 32'(mem_en1), 32'd1);
    chk("rd_we", 32'(mem_we1), 32'd0);
    chk("rd_addr", 32'(mem_addr1), 32'd2);
    chk("rd_stall_t1", 32'(stall1), 32'd1);
    step();
    chk("rd_en_wait", 32'(mem_en1), 32'd0);
    chk("rd_done_early", 32'(c1.done), 32'd0);
    chk("rd_stall_t2", 32'(stall1), 32'd1);
    step();
    chk("rd_done", 32'(c1.done), 32'd1);
    chk("rd_rdata", c1.rdata, 32'hDEAD_BEEF);
    chk("rd_stall_done", 32'(stall1), 32'd0);
    c1.req = 0;
    step();
    chk("rd_done_pulse", 32'(c1.done), 32'd0);
    chk("rd_rdata_hold", c1.rdata, 32'hDEAD_BEEF);

    // Core write 0x12345678 to 0x10, then read it back
    c1.req = 1; c1.we = 1; c1.addr = 32'h10; c1.wdata = 32'h1234_5678;
    step();
    chk("wr_en", 32'(mem_en1), 32'd1);
    chk("wr_we", 32'(mem_we1), 32'd1);
    chk("wr_addr", 32'(mem_addr1), 32'd4);
    chk("wr_wdata", mem_wdata1, 32'h1234_5678);
    step();
    chk("wr_we_wait", 32'(mem_we1), 32'd0);
    step();
    chk("wr_done", 32'(c1.done), 32'd1);
    chk("wr_rdata_keep", c1.rdata, 32'hDEAD_BEEF);
    c1.req = 0;
    step();
    c1.req = 1; c1.we = 0; c1.wdata = '0;
    step(); step(); step();
    chk("wrrd_done", 32'(c1.done), 32'd1);
    chk("wrrd_rdata", c1.rdata, 32'h1234_5678);
    c1.req = 0;
    step();

    // DMA only, three back-to-back reads
    d1.req = 1; d1.we = 0;
    for (int k = 0; k < 3; k++) begin
      d1.addr = 32'h14 + 32'(4 * k);
      #1;
      chk("dma_stall_idle", 32'(stall1), 32'd0);
      step();
      chk("dma_addr", 32'(mem_addr1), 32'(5 + k));
      chk("dma_stall", 32'(stall1), 32'd0);
      step(); step();
      chk("dma_d_done", 32'(d1.done), 32'd1);
      chk("dma_c_done", 32'(c1.done), 32'd0);
      chk("dma_rdata", d1.rdata, 32'hC0DE_0005 + 32'(k));
      step();
    end
    d1.req = 0;
    step();

    // Reset during WAIT of a core read, then a fresh access
    c1.req = 1; c1.we = 0; c1.addr = 32'h8;
    step(); step();
    rst = 1'b1;
    #1;
    chk("rstw_busy", 32'(busy1), 32'd0);
    chk("rstw_stall", 32'(stall1), 32'd0);
    chk("rstw_addr", 32'(mem_addr1), 32'd0);
    chk("rstw_c_rdata", c1.rdata, 32'd0);
    step();
    chk("rstw_c_done", 32'(c1.done), 32'd0);
    rst = 1'b0;
    step();
    chk("rstw_en", 32'(mem_en1), 32'd1);
    chk("rstw_addr2", 32'(mem_addr1), 32'd2);
    step();
    chk("rstw_done_early", 32'(c1.done), 32'd0);
    step();
    chk("rstw_done", 32'(c1.done), 32'd1);
    chk("rstw_rdata", c1.rdata, 32'hDEAD_BEEF);
    c1.req = 0;
    step();

    // MEM_LAT=3 read with wrapped address 0x1000_0008
    c3.req = 1; c3.we = 0; c3.addr = 32'h1000_0008;
    #1;
    chk("l3_stall_t", 32'(stall3), 32'd1);
    step();
    chk("l3_en", 32'(mem_en3), 32'd1);
    chk("l3_addr", 32'(mem_addr3), 32'd2);
    step(); step(); step();
    chk("l3_done_t4", 32'(c3.done), 32'd0);
    chk("l3_stall_t4", 32'(stall3), 32'd1);
    step();
    chk("l3_done", 32'(c3.done), 32'd1);
    chk("l3_rdata", c3.rdata, 32'hDEAD_BEEF);
    chk("l3_stall_done", 32'(stall3), 32'd0);
    c3.req = 0;
    step();
    chk("l3_done_pulse", 32'(c3.done), 32'd0);
    chk("l3_busy", 32'(busy3), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
